// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: IO window location, register
// offsets and bus direction encoding.
package mem_io_responder_pkg;

    localparam logic [31:0] IO_BASE        = 32'h0003_0000;
    localparam logic [15:0] IO_CONSOLE_OFS = 16'h0000;
    localparam logic [15:0] IO_HALT_OFS    = 16'h0004;
    localparam logic        R_NW_READ      = 1'b1;

    typedef enum logic [1:0] {
        IO_REG_CONSOLE,
        IO_REG_HALT,
        IO_REG_OTHER
    } io_reg_e;

    function automatic io_reg_e io_reg_decode(input logic [15:0] ofs);
        if (ofs == IO_CONSOLE_OFS) return IO_REG_CONSOLE;
        if (ofs == IO_HALT_OFS)    return IO_REG_HALT;
        return IO_REG_OTHER;
    endfunction

endpackage

// File: rtl/mem_io_responder_fifo.sv
// Console output FIFO: synchronous push/pop, async active-low reset of the
// pointers and count only; storage is left unreset.
module io_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the byte-serial CPU bus: RAM, console FIFO and
// halt flag behind a fixed IO window, one request per cycle, read latency 1.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_write,
    input  logic        r_nw,
    output logic [7:0]  mem_read,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic        overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    ram_q [2**ADDR_WIDTH];
    logic [7:0]    mem_read_q, mem_read_d;
    logic          halt_q, halt_d;
    logic          overflow_q, overflow_d;
    logic          io_sel, is_read, is_write;
    io_reg_e       io_reg;
    logic          fifo_push, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          unused_addr;

    assign unused_addr = ^mem_addr[31:18];

    assign io_sel   = (mem_addr[17:16] == IO_BASE[17:16]);
    assign io_reg   = io_reg_decode(mem_addr[15:0]);
    assign is_read  = rdy_in && (r_nw == R_NW_READ);
    assign is_write = rdy_in && (r_nw != R_NW_READ);

    assign fifo_push = is_write && io_sel && (io_reg == IO_REG_CONSOLE);

    io_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push_i   (fifo_push),
        .din_i    (mem_write),
        .pop_i    (tx_ready),
        .dout_o   (tx_data),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (fifo_count)
    );

    always_comb begin
        mem_read_d = mem_read_q;
        halt_d     = halt_q;
        overflow_d = overflow_q;
        if (is_read) begin
            if (!io_sel)                    mem_read_d = ram_q[mem_addr[ADDR_WIDTH-1:0]];
            else if (io_reg == IO_REG_HALT) mem_read_d = 8'(fifo_count);
            else                            mem_read_d = 8'h00;
        end
        if (is_write && io_sel && (io_reg == IO_REG_HALT)) halt_d = 1'b1;
        // A full FIFO drops the byte even if the consumer pops this cycle.
        if (fifo_push && fifo_full) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_read_q <= 8'h00;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mem_read_q <= mem_read_d;
            halt_q     <= halt_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (is_write && !io_sel) ram_q[mem_addr[ADDR_WIDTH-1:0]] <= mem_write;
    end

    assign mem_read       = mem_read_q;
    assign halt           = halt_q;
    assign overflow       = overflow_q;
    assign tx_valid       = !fifo_empty;
    assign io_buffer_full = (fifo_count >= CW'(FIFO_DEPTH - FULL_MARGIN));

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM latency, console FIFO fill/drain,
// rdy_in gating and asynchronous reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] mem_addr;
    logic [7:0]  mem_write;
    logic        r_nw;
    logic [7:0]  mem_read;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        .mem_addr       (mem_addr),
        .mem_write      (mem_write),
        .r_nw           (r_nw),
        .mem_read       (mem_read),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .halt           (halt),
        .overflow       (overflow)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        mem_addr  = a;
        mem_write = d;
        r_nw      = 1'b0;
        step();
    endtask

    task automatic rd(input logic [31:0] a);
        mem_addr  = a;
        mem_write = 8'h00;
        r_nw      = 1'b1;
        step();
    endtask

    task automatic idle();
        rd(32'h0);
    endtask

    logic [7:0] bytes4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        rst_n_in  = 1'b0;
        rdy_in    = 1'b1;
        tx_ready  = 1'b0;
        mem_addr  = 32'h0;
        mem_write = 8'h00;
        r_nw      = 1'b1;
        #12;
        check("rst_mem_read", mem_read, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_halt", halt, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_full", io_buffer_full, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        step();

        // 1: write then read next cycle
        wr(32'h10, 8'hA5);
        rd(32'h10);
        check("t1_rd", mem_read, 8'hA5);

        // 2: four bytes back in order, latency 1
        for (int i = 0; i < 4; i++) wr(32'h100 + i, bytes4[i]);
        for (int i = 0; i < 4; i++) begin
            rd(32'h100 + i);
            check($sformatf("t2_rd%0d", i), mem_read, bytes4[i]);
        end

        // 3: fill console FIFO with tx_ready low
        for (int i = 1; i <= 6; i++) begin
            wr(32'h30000, 8'(i));
            if (i == 5) check("t3_full_at5", io_buffer_full, 1'b0);
        end
        check("t3_full_at6", io_buffer_full, 1'b1);
        check("t3_tx_valid", tx_valid, 1'b1);
        check("t3_head", tx_data, 8'h01);
        rd(32'h30004);
        check("t3_count6", mem_read, 8'd6);
        wr(32'h30000, 8'h07);
        wr(32'h30000, 8'h08);
        check("t3_no_ovf_at8", overflow, 1'b0);
        wr(32'h30000, 8'h09);
        check("t3_ovf", overflow, 1'b1);
        rd(32'h30004);
        check("t3_count8", mem_read, 8'd8);
        rd(32'h30000);
        check("t3_rd_console", mem_read, 8'h00);
        rd(32'h30008);
        check("t3_rd_other", mem_read, 8'h00);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("t3_drain%0d", i), tx_data, 8'(i));
            idle();
        end
        check("t3_empty", tx_valid, 1'b0);
        check("t3_not_full", io_buffer_full, 1'b0);
        check("t3_ovf_sticky", overflow, 1'b1);

        // 4: simultaneous push and pop with 3 queued
        tx_ready = 1'b0;
        wr(32'h30000, 8'h31);
        wr(32'h30000, 8'h32);
        wr(32'h30000, 8'h33);
        check("t4_head", tx_data, 8'h31);
        tx_ready = 1'b1;
        wr(32'h30000, 8'h34);
        tx_ready = 1'b0;
        rd(32'h30004);
        check("t4_count3", mem_read, 8'd3);
        tx_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            check($sformatf("t4_drain%0d", i), tx_data, 8'h30 + 8'(i));
            idle();
        end
        check("t4_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // 5: rdy_in low blocks writes and holds mem_read
        wr(32'h20, 8'h77);
        rd(32'h20);
        check("t5_pre", mem_read, 8'h77);
        rdy_in = 1'b0;
        wr(32'h20, 8'h5A);
        wr(32'h30004, 8'h01);
        rd(32'h100);
        check("t5_halt_blocked", halt, 1'b0);
        check("t5_held", mem_read, 8'h77);
        rdy_in = 1'b1;
        rd(32'h20);
        check("t5_ram_kept", mem_read, 8'h77);
        wr(32'h30004, 8'h01);
        check("t5_halt", halt, 1'b1);

        // 6: async reset mid-cycle with 3 bytes queued
        wr(32'h30000, 8'hC1);
        wr(32'h30000, 8'hC2);
        wr(32'h30000, 8'hC3);
        check("t6_valid_pre", tx_valid, 1'b1);
        rst_n_in = 1'b0;
        #1;
        check("t6_tx_valid", tx_valid, 1'b0);
        check("t6_halt", halt, 1'b0);
        check("t6_mem_read", mem_read, 8'h00);
        check("t6_overflow", overflow, 1'b0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        rd(32'h30004);
        check("t6_count0", mem_read, 8'd0);
        rd(32'h10);
        check("t6_ram_kept", mem_read, 8'hA5);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
